// File: rtl/quarterwave_pkg.sv
// Shared types and elaboration-time table math for the quarter-wave NCO.
package quarterwave_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    localparam real PI = 3.14159265358979;

    function automatic int unsigned quarter_len(input int unsigned lut_width);
        return 32'(1) << (lut_width - 2);
    endfunction

    function automatic int peak_amp(input int unsigned sine_width);
        return (1 << (sine_width - 1)) - 2;
    endfunction

    // Entries are non-negative, so +0.5 then truncate is round-to-nearest.
    function automatic int sine_entry(input int unsigned k, input int unsigned lut_width,
                                      input int unsigned sine_width);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(32'(1) << lut_width);
        return $rtoi(real'(peak_amp(sine_width)) * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/quarterwave_nco_if.sv
// Control/sample bundle of the NCO; cosine exists only with QUARTERWAVE_NCO_COS_EN.
interface quarterwave_nco_if #(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned SINE_WIDTH  = 7
);
    logic                          en;
    logic                          clear;
    logic [PHASE_WIDTH-1:0]        fcw;
    logic [PHASE_WIDTH-1:0]        phase_offset;
    logic signed [SINE_WIDTH-1:0]  sine;
`ifdef QUARTERWAVE_NCO_COS_EN
    logic signed [SINE_WIDTH-1:0]  cosine;
`endif
    logic                          out_valid;

    modport master (
        output en, clear, fcw, phase_offset,
`ifdef QUARTERWAVE_NCO_COS_EN
        input  cosine,
`endif
        input  sine, out_valid
    );

    modport slave (
        input  en, clear, fcw, phase_offset,
`ifdef QUARTERWAVE_NCO_COS_EN
        output cosine,
`endif
        output sine, out_valid
    );
endinterface

// File: rtl/quarterwave_rom.sv
// Registered quarter-wave magnitude ROM; second read port with QUARTERWAVE_NCO_COS_EN.
module quarterwave_rom
    import quarterwave_pkg::*;
#(
    parameter int unsigned LUT_WIDTH  = 8,
    parameter int unsigned SINE_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LUT_WIDTH-3:0]  addr_a,
    output logic [SINE_WIDTH-1:0] data_a
`ifdef QUARTERWAVE_NCO_COS_EN
    ,
    input  logic [LUT_WIDTH-3:0]  addr_b,
    output logic [SINE_WIDTH-1:0] data_b
`endif
);
    localparam int unsigned QLEN = quarter_len(LUT_WIDTH);

    logic [SINE_WIDTH-1:0] table_c [QLEN];

    for (genvar i = 0; i < QLEN; i++) begin : g_table
        assign table_c[i] = SINE_WIDTH'(sine_entry(32'(i), LUT_WIDTH, SINE_WIDTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a <= '0;
        end else begin
            data_a <= table_c[addr_a];
        end
    end

`ifdef QUARTERWAVE_NCO_COS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_b <= '0;
        end else begin
            data_b <= table_c[addr_b];
        end
    end
`endif

endmodule

// File: rtl/quarterwave_nco.sv
// Three-stage quarter-wave NCO: phase/quadrant, ROM read, peak+sign restore.
// Optional cosine output with QUARTERWAVE_NCO_COS_EN.
module quarterwave_nco
    import quarterwave_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned LUT_WIDTH   = 8,
    parameter int unsigned SINE_WIDTH  = 7
) (
    input  logic              clk,
    input  logic              reset,
    quarterwave_nco_if.slave  bus
);
    localparam int unsigned KW = LUT_WIDTH - 2;
    localparam logic [SINE_WIDTH-1:0] PEAK = SINE_WIDTH'(peak_amp(SINE_WIDTH));

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase_c;
    logic                   accept_c;

    quadrant_e              q1, q2;
    logic [KW-1:0]          k1;
    logic                   v1, v2, kz2;
    logic [KW-1:0]          addr_s_c;
    logic [SINE_WIDTH-1:0]  rom_s;
    logic [SINE_WIDTH-1:0]  sine_c;

    assign accept_c = bus.en & ~bus.clear;
    assign phase_c  = acc + bus.phase_offset;

    // Stage 1: accumulator and quadrant/offset split of the looked-up phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            q1  <= Q0;
            k1  <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= accept_c;
            if (bus.clear) begin
                acc <= '0;
            end else if (bus.en) begin
                acc <= acc + bus.fcw;
            end
            if (accept_c) begin
                q1 <= quadrant_e'(phase_c[PHASE_WIDTH-1 -: 2]);
                k1 <= phase_c[PHASE_WIDTH-3 -: KW];
            end
        end
    end

    // Odd quadrants mirror the table; k==0 wraps to 0 and is replaced by the peak later.
    assign addr_s_c = (q1 == Q1 || q1 == Q3) ? KW'(0) - k1 : k1;

    // Stage 2: side-band alongside the registered ROM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q2  <= Q0;
            kz2 <= 1'b0;
            v2  <= 1'b0;
        end else begin
            q2  <= q1;
            kz2 <= (k1 == '0);
            v2  <= v1;
        end
    end

`ifdef QUARTERWAVE_NCO_COS_EN
    logic [KW-1:0]          addr_c_c;
    logic [SINE_WIDTH-1:0]  rom_c;
    logic [SINE_WIDTH-1:0]  cosine_c;
    quadrant_e              qc2_c;

    assign addr_c_c = (q1 == Q0 || q1 == Q2) ? KW'(0) - k1 : k1;

    quarterwave_rom #(.LUT_WIDTH(LUT_WIDTH), .SINE_WIDTH(SINE_WIDTH)) u_rom (
        .clk    (clk),
        .reset  (reset),
        .addr_a (addr_s_c),
        .data_a (rom_s),
        .addr_b (addr_c_c),
        .data_b (rom_c)
    );
`else
    quarterwave_rom #(.LUT_WIDTH(LUT_WIDTH), .SINE_WIDTH(SINE_WIDTH)) u_rom (
        .clk    (clk),
        .reset  (reset),
        .addr_a (addr_s_c),
        .data_a (rom_s)
    );
`endif

    // Stage 3 combinational: peak substitution and sign restore.
    always_comb begin
        logic [SINE_WIDTH-1:0] mag;
        mag    = rom_s;
        sine_c = '0;
        if ((q2 == Q1 || q2 == Q3) && kz2) begin
            mag = PEAK;
        end
        sine_c = (q2 == Q2 || q2 == Q3) ? SINE_WIDTH'(0) - mag : mag;
    end

`ifdef QUARTERWAVE_NCO_COS_EN
    always_comb begin
        logic [SINE_WIDTH-1:0] mag;
        qc2_c    = quadrant_e'(q2 + 2'd1);
        mag      = rom_c;
        cosine_c = '0;
        if ((qc2_c == Q1 || qc2_c == Q3) && kz2) begin
            mag = PEAK;
        end
        cosine_c = (qc2_c == Q2 || qc2_c == Q3) ? SINE_WIDTH'(0) - mag : mag;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sine      <= '0;
            bus.out_valid <= 1'b0;
`ifdef QUARTERWAVE_NCO_COS_EN
            bus.cosine    <= '0;
`endif
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                bus.sine   <= sine_c;
`ifdef QUARTERWAVE_NCO_COS_EN
                bus.cosine <= cosine_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_quarterwave_nco.sv
// Directed bench for quarterwave_nco (defaults); cosine checks with QUARTERWAVE_NCO_COS_EN.
module tb_quarterwave_nco;

    typedef struct {
        int idx;
        int val;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   samp [0:299];
    int   csamp [0:299];
    int   got;
    int   obs_v [0:15];
    int   obs_s [0:15];

    vec_t sweep_v [22];
    vec_t wrap_v  [14];
    vec_t cos_v   [6];

    always #5 clk = ~clk;

    quarterwave_nco_if #(.PHASE_WIDTH(16), .SINE_WIDTH(7)) bus ();

    quarterwave_nco #(.PHASE_WIDTH(16), .LUT_WIDTH(8), .SINE_WIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        bus.clear = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Hold en high and collect n valid samples, bounded by a cycle budget.
    task automatic capture(input logic [15:0] f, input logic [15:0] off, input int n);
        bus.fcw = f;
        bus.phase_offset = off;
        bus.clear = 1'b0;
        bus.en = 1'b1;
        got = 0;
        for (int c = 0; c < n + 20 && got < n; c++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                samp[got] = int'($signed(bus.sine));
`ifdef QUARTERWAVE_NCO_COS_EN
                csamp[got] = int'($signed(bus.cosine));
`endif
                got++;
            end
        end
        bus.en = 1'b0;
        check("capture_count", got, n);
    endtask

    // Apply per-cycle en/clear bits; return the out_valid pattern (bit i = after tick i+1).
    task automatic run_seq(input logic [15:0] en_bits, input logic [15:0] clr_bits,
                           input int ncyc, output int vpat);
        vpat = 0;
        for (int c = 0; c < ncyc; c++) begin
            bus.en = en_bits[c];
            bus.clear = clr_bits[c];
            tick();
            obs_v[c + 1] = int'(bus.out_valid);
            obs_s[c + 1] = int'($signed(bus.sine));
            if (bus.out_valid === 1'b1) vpat |= (1 << c);
        end
        bus.en = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        int vpat;

        sweep_v = '{'{0, 0}, '{1, 2}, '{2, 3}, '{3, 5}, '{4, 6}, '{5, 8},
                    '{16, 24}, '{32, 44}, '{48, 57}, '{60, 62}, '{63, 62}, '{64, 62},
                    '{65, 62}, '{96, 44}, '{120, 12}, '{128, 0}, '{129, -2}, '{136, -12},
                    '{160, -44}, '{192, -62}, '{193, -62}, '{256, 0}};
        wrap_v  = '{'{0, 62}, '{1, 62}, '{2, 62}, '{32, 44}, '{48, 24}, '{56, 12},
                    '{63, 2}, '{64, 0}, '{65, -2}, '{66, -3}, '{96, -44}, '{128, -62},
                    '{192, 0}, '{256, 62}};
        cos_v   = '{'{0, 62}, '{32, 44}, '{64, 0}, '{128, -62}, '{192, 0}, '{224, 44}};

        bus.en = 1'b0;
        bus.clear = 1'b0;
        bus.fcw = '0;
        bus.phase_offset = '0;
        #1 reset = 1'b1;
        tick();
        check("reset_sine", int'($signed(bus.sine)), 0);
        check("reset_valid", int'(bus.out_valid), 0);
        reset = 1'b0;

        // Full-period sweep.
        capture(16'd256, 16'h0000, 258);
        for (int i = 0; i < 22; i++)
            check($sformatf("sweep[%0d]", sweep_v[i].idx), samp[sweep_v[i].idx], sweep_v[i].val);
`ifdef QUARTERWAVE_NCO_COS_EN
        for (int i = 0; i < 6; i++)
            check($sformatf("cos[%0d]", cos_v[i].idx), csamp[cos_v[i].idx], cos_v[i].val);
`endif

        // Near-full-scale fcw wraps the accumulator every sample.
        do_reset();
        capture(16'hFF00, 16'h4000, 258);
        for (int i = 0; i < 14; i++)
            check($sformatf("wrap[%0d]", wrap_v[i].idx), samp[wrap_v[i].idx], wrap_v[i].val);

        // fcw=0 holds the offset phase.
        do_reset();
        capture(16'h0000, 16'h4000, 5);
        for (int i = 0; i < 5; i++) check($sformatf("hold62[%0d]", i), samp[i], 62);
        do_reset();
        capture(16'h0000, 16'h2000, 3);
        for (int i = 0; i < 3; i++) check($sformatf("hold44[%0d]", i), samp[i], 44);

        // Latency and bubbles: en at cycles 0 and 3.
        do_reset();
        bus.fcw = 16'd4096;
        bus.phase_offset = 16'h0000;
        run_seq(16'b0000_0000_0000_1001, 16'h0000, 8, vpat);
        check("bubble_valid_pattern", vpat, 32'b0010_0100);
        check("bubble_first", obs_s[3], 0);
        check("bubble_second", obs_s[6], 24);

        // Clear wins over en; the next en reads the offset phase.
        do_reset();
        bus.fcw = 16'd4096;
        bus.phase_offset = 16'h4000;
        run_seq(16'b0000_0000_0001_1111, 16'b0000_0000_0000_1000, 9, vpat);
        check("clear_valid_pattern", vpat, 32'b0101_1100);
        check("clear_pre0", obs_s[3], 62);
        check("clear_pre1", obs_s[4], 57);
        check("clear_pre2", obs_s[5], 44);
        check("clear_post", obs_s[7], 62);

        // Asynchronous reset mid-stream.
        do_reset();
        bus.fcw = 16'd256;
        bus.phase_offset = 16'h0000;
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("pre_reset_valid", int'(bus.out_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_sine", int'($signed(bus.sine)), 0);
        check("async_reset_valid", int'(bus.out_valid), 0);
        bus.en = 1'b0;
        tick();
        reset = 1'b0;
        bus.phase_offset = 16'h4000;
        bus.en = 1'b1;
        tick();
        tick();
        check("restart_no_early_valid", int'(bus.out_valid), 0);
        tick();
        check("restart_valid", int'(bus.out_valid), 1);
        check("restart_sine", int'($signed(bus.sine)), 62);
        tick();
        check("restart_second", int'($signed(bus.sine)), 62);
        bus.en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quarterwave_nco.md
# quarterwave_nco

Parametrised numerically controlled oscillator built around a quarter-wave sine table. It keeps a phase accumulator, folds each phase into one quadrant and reads a registered quarter-wave ROM. It then restores the sign and streams signed sine (and optionally cosine) samples with a valid strobe. It sits in the SineGenerator path and feeds the mixer/DDC stages. It replaces the fixed 64-entry, 7-bit combinational table with a pipelined, width-generic oscillator.

## Interface
- PHASE_WIDTH, 16, phase accumulator width; the accumulator wraps modulo 2^PHASE_WIDTH.
- LUT_WIDTH, 8, full-wave address bits; the quarter table holds Q = 2^(LUT_WIDTH-2) entries.
- SINE_WIDTH, 7, signed output width; peak amplitude A = 2^(SINE_WIDTH-1) - 2.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance the accumulator and issue one sample this cycle.
- clear  in  1  synchronous accumulator clear.
- fcw  in  PHASE_WIDTH  frequency control word (unsigned phase increment).
- phase_offset  in  PHASE_WIDTH  phase added to the accumulator value before lookup.
- sine  out  SINE_WIDTH  signed sine sample.
- cosine  out  SINE_WIDTH  signed cosine sample (only with QUARTERWAVE_NCO_COS_EN).
- out_valid  out  1  sine/cosine hold a new sample this cycle.

## Operation
- Table contents: rom[k] = round(A * sin(2*pi*k / 2^LUT_WIDTH)) for k = 0..Q-1. The defaults reproduce the existing 0..62 table.
- Phase: p = (acc + phase_offset) mod 2^PHASE_WIDTH. Index idx = p[PHASE_WIDTH-1 -: LUT_WIDTH]; the lower bits are truncated, with no dithering. Quadrant q = idx[LUT_WIDTH-1:LUT_WIDTH-2]; k = idx[LUT_WIDTH-3:0].
- Fold:
  - q0: mag = rom[k]
  - q1: mag = A if k==0, else rom[Q-k]
  - q2: -rom[k]
  - q3: -(A if k==0, else rom[Q-k])
- Negation is two's complement. Outputs never exceed ±A, so no saturation is needed.
- Accumulator update:
  - en=1, clear=0: acc <= acc + fcw, wrapping; a sample is issued using the pre-update acc.
  - clear=1: acc <= 0 and no sample is issued, regardless of en. Samples already in flight complete normally.
  - en=0: acc holds and a pipeline bubble is inserted.
- fcw=0 with en held high gives a constant output at the phase_offset value.
- fcw and phase_offset are sampled in the same cycle as en.

## Timing
- Stage 1: register idx and q, and update acc.
- Stage 2: registered ROM read of the folded address; q and the k==0 flag are delayed alongside.
- Stage 3: peak substitution and sign restore into output registers.
- Latency: en high at edge n gives out_valid high and the matching sample at edge n+3.
- Throughput: one sample per clock, with no backpressure.
- out_valid is the en-not-clear term delayed by 3 cycles.
- Reset values: acc, all pipeline registers, sine, cosine and out_valid are 0.
- Reset asserted mid-stream clears everything asynchronously, and in-flight samples are discarded. The first valid output after reset deassertion arrives 3 cycles after the first accepted en.

## Configuration
- QUARTERWAVE_NCO_COS_EN defined:
  - A second fold path is added using the quadrant index q+1 (mod 4) with the same k.
  - The ROM is read dual-port and the cosine port exists, with cosine aligned to sine.
- Not defined:
  - The cosine port and its logic are absent.
  - The ROM is single-port.

## Structure
- Package quarterwave_pkg holds:
  - the quadrant enum (Q0..Q3);
  - localparam functions for Q and A from the parameters;
  - the elaboration-time table function sine_entry(k, LUT_WIDTH, SINE_WIDTH), using real arithmetic.
- Sub-module quarterwave_rom: a registered, one- or two-read-port ROM parametrised by LUT_WIDTH and SINE_WIDTH, initialised from sine_entry.

## Test plan
All scenarios use the defaults.
- Reset check: reset pulse mid-stream → sine=0 and out_valid=0 immediately; acc restarts from 0.
- Full-period sweep: fcw=256, offset=0, en held high → outputs are 0,2,3,5,… Sample 64 is 62, sample 128 is 0, sample 192 is -62 and sample 193 is -62. The sequence repeats every 256 samples.
- Latency and bubbles: en high for 1 cycle, low for 2, then high for 1 → exactly two out_valid pulses, each 3 cycles after its en, with correct samples.
- Clear precedence: clear=1 and en=1 in the same cycle → no sample for that cycle. The next en yields sine=rom-derived value at phase_offset.
- Wrap and offset:
  - fcw=0xFF00, offset=0x4000 → the first sample is 62, and the accumulator wraps without a glitch.
  - fcw=0 → output held constant at 62.
- COS_EN variant: fcw=256 → cosine[n] == sine[n+64] for all n; cosine's first sample is 62.
